// File: rtl/key_event_classifier.sv
// key_event_classifier: debounces an active-low push-button on press and release and
// classifies each key event as short press, long press or auto-repeat.
module key_event_classifier #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_state,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int HW = $clog2(LONG_CYC + 1);
   localparam int RW = $clog2(REPEAT_CYC + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
   localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_CYC);

   typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB} state_t;

   state_t        state;
   logic          sync1, ks, from_long;
   logic [DW-1:0] db_cnt;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rep_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         ks    <= 1'b1;
      end else begin
         sync1 <= key_in;
         ks    <= sync1;
      end
   end

   // ks is the synchronised pin level: 0 means the key is physically pressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         key_state    <= 1'b0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         from_long    <= 1'b0;
         db_cnt       <= '0;
         hold_cnt     <= '0;
         rep_cnt      <= '0;
      end else begin
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         case (state)
            IDLE:
               if (!ks) begin
                  state  <= PRESS_DB;
                  db_cnt <= '0;
               end
            PRESS_DB:
               if (ks) state <= IDLE;
               else if (db_cnt == DB_LAST) begin
                  state     <= HELD;
                  key_state <= 1'b1;
                  hold_cnt  <= '0;
                  from_long <= 1'b0;
               end else db_cnt <= db_cnt + 1'b1;
            HELD: begin
               hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
               if (ks) begin
                  state  <= RELEASE_DB;
                  db_cnt <= '0;
               end else if (hold_cnt >= HOLD_LAST) begin
                  long_press <= 1'b1;
                  from_long  <= 1'b1;
                  rep_cnt    <= '0;
                  state      <= LONG_HELD;
               end
            end
            // a release that coincides with a repeat boundary suppresses the pulse
            LONG_HELD:
               if (ks) begin
                  state   <= RELEASE_DB;
                  db_cnt  <= '0;
                  rep_cnt <= (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
               end else if (rep_cnt >= REP_LAST) begin
                  repeat_pulse <= 1'b1;
                  rep_cnt      <= '0;
               end else rep_cnt <= rep_cnt + 1'b1;
            RELEASE_DB:
               if (!ks) state <= from_long ? LONG_HELD : HELD;
               else if (db_cnt == DB_LAST) begin
                  state       <= IDLE;
                  key_state   <= 1'b0;
                  short_press <= !from_long;
               end else db_cnt <= db_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({short_press, long_press, repeat_pulse}));
   a_long_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
      long_press |=> !long_press);
   a_short_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
      short_press |=> !short_press);

endmodule

// File: tb/tb_key_event_classifier.sv
// tb_key_event_classifier: directed stimulus checked every cycle against a run-length /
// hold-time model of the key, plus hand-computed latency and event-count expectations.
module tb_key_event_classifier;
   localparam int DB = 4, LG = 20, RP = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_in = 1'b1;
   logic key_state, short_press, long_press, repeat_pulse;

   key_event_classifier #(.DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
      .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   int n_rise = 0, n_fall = 0, n_short = 0, n_long = 0, n_rep = 0;
   int t_rise = -1, t_fall = -1, t_short = -1, t_long = -1;
   int rep_q[$];
   logic prev_ks = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: the pin seen two edges late; the debounced level flips after DB+1 consecutive
   // opposite samples; hold and repeat time accumulate only while the level is settled.
   logic m_s1, m_s2, m_level, m_long_fired, e_ks, e_sp, e_lp, e_rp;
   bit   pressed, settled;
   int   m_opp, m_held, m_rep;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_long_fired = 1'b0;
         m_opp = 0; m_held = 0; m_rep = 0;
         e_ks = 1'b0; e_sp = 1'b0; e_lp = 1'b0; e_rp = 1'b0;
      end else begin
         e_sp = 1'b0; e_lp = 1'b0; e_rp = 1'b0;
         pressed = !m_s2;
         settled = m_level && (m_opp == 0);
         if (settled && !m_long_fired) begin
            m_held++;
            if (pressed && m_held >= LG) begin
               e_lp = 1'b1; m_long_fired = 1'b1; m_rep = 0;
            end
         end else if (settled) begin
            m_rep++;
            if (pressed && m_rep >= RP) begin
               e_rp = 1'b1; m_rep = 0;
            end
         end
         if (pressed != m_level) begin
            m_opp++;
            if (m_opp == DB + 1) begin
               m_level = pressed; m_opp = 0;
               if (!pressed && !m_long_fired) e_sp = 1'b1;
               if (pressed) begin
                  m_held = 0; m_long_fired = 1'b0; m_rep = 0;
               end
            end
         end else m_opp = 0;
         e_ks = m_level;
         m_s2 = m_s1; m_s1 = key_in;
      end
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      chk("key_state", key_state, e_ks);
      chk("short_press", short_press, e_sp);
      chk("long_press", long_press, e_lp);
      chk("repeat_pulse", repeat_pulse, e_rp);
      if (key_state === 1'b1 && prev_ks === 1'b0) begin n_rise++; t_rise = cyc; end
      if (key_state === 1'b0 && prev_ks === 1'b1) begin n_fall++; t_fall = cyc; end
      if (short_press === 1'b1) begin n_short++; t_short = cyc; end
      if (long_press === 1'b1) begin n_long++; t_long = cyc; end
      if (repeat_pulse === 1'b1) begin n_rep++; rep_q.push_back(cyc); end
      prev_ks = key_state;
   end

   function automatic int rep_at(input int i);
      return (rep_q.size() > i) ? rep_q[i] : -1000;
   endfunction

   task automatic go_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_rise(input int budget);
      int n0 = n_rise;
      for (int i = 0; i < budget && n_rise == n0; i++) @(negedge clk);
      chk("wait_rise", n_rise != n0, 1);
   endtask

   task automatic wait_long(input int budget);
      int n0 = n_long;
      for (int i = 0; i < budget && n_long == n0; i++) @(negedge clk);
      chk("wait_long", n_long != n0, 1);
   endtask

   int tf, tr, r0, l0, q, s_rise, s_fall, s_short, s_long, s_rep;

   task automatic snap();
      s_rise = n_rise; s_fall = n_fall; s_short = n_short; s_long = n_long; s_rep = n_rep;
   endtask

   initial begin
      // 1: reset held with a toggling pin, then idle
      repeat (8) @(negedge clk) key_in = ~key_in;
      chk("reset_outputs", {key_state, short_press, long_press, repeat_pulse}, 4'b0);
      key_in = 1'b1;
      rst_n = 1'b1;
      snap();
      go_until(cyc + 10);
      chk("idle_events", n_rise + n_short + n_long + n_rep - s_rise - s_short - s_long - s_rep, 0);
      // 2: 3-cycle glitch is rejected
      snap();
      key_in = 1'b0;
      go_until(cyc + 3);
      key_in = 1'b1;
      go_until(cyc + 12);
      chk("glitch_rise", n_rise - s_rise, 0);
      chk("glitch_pulses", n_short + n_long + n_rep - s_short - s_long - s_rep, 0);
      // 3: short press
      snap();
      key_in = 1'b0; tf = cyc;
      go_until(tf + 12);
      key_in = 1'b1; tr = cyc;
      go_until(tr + 12);
      chk("short_rise_lat", t_rise - tf, 7);
      chk("short_pulse_lat", t_short - tr, 7);
      chk("short_fall_lat", t_fall - tr, 7);
      chk("short_count", n_short - s_short, 1);
      chk("short_no_long", n_long - s_long, 0);
      // 4: long hold with auto-repeat
      snap();
      key_in = 1'b0; tf = cyc;
      go_until(tf + 60);
      key_in = 1'b1; tr = cyc;
      go_until(tr + 14);
      chk("long_rise_lat", t_rise - tf, 7);
      chk("long_count", n_long - s_long, 1);
      chk("long_lat", t_long - t_rise, 20);
      chk("rep1_offset", rep_at(s_rep) - t_long, 8);
      chk("rep2_offset", rep_at(s_rep + 1) - t_long, 16);
      chk("rep_count", n_rep - s_rep, 4);
      chk("long_no_short", n_short - s_short, 0);
      chk("long_fall_lat", t_fall - tr, 7);
      // 5: release bounce at hold_cnt=5 freezes the hold for two cycles
      snap();
      key_in = 1'b0;
      wait_rise(20);
      r0 = t_rise;
      go_until(r0 + 3);
      key_in = 1'b1;
      go_until(r0 + 5);
      key_in = 1'b0;
      go_until(r0 + 30);
      chk("bounce_no_fall", n_fall - s_fall, 0);
      chk("bounce_no_short", n_short - s_short, 0);
      chk("bounce_long_lat", t_long - r0, 22);
      chk("bounce_long_count", n_long - s_long, 1);
      key_in = 1'b1;
      go_until(cyc + 14);
      chk("bounce_release_short", n_short - s_short, 0);
      // 7: release seen on the very cycle the hold would expire
      snap();
      key_in = 1'b0;
      wait_rise(20);
      r0 = t_rise;
      go_until(r0 + 17);
      key_in = 1'b1; tr = cyc;
      go_until(tr + 14);
      chk("edge_hold_no_long", n_long - s_long, 0);
      chk("edge_hold_short", n_short - s_short, 1);
      chk("edge_hold_short_lat", t_short - tr, 7);
      // 8: release seen on the very cycle a repeat would fire
      snap();
      key_in = 1'b0;
      wait_long(60);
      l0 = t_long;
      go_until(l0 + 5);
      key_in = 1'b1;
      go_until(l0 + 20);
      chk("edge_rep_no_repeat", n_rep - s_rep, 0);
      chk("edge_rep_no_short", n_short - s_short, 0);
      chk("edge_rep_fall", n_fall - s_fall, 1);
      // 6: reset in LONG_HELD with the key still down
      snap();
      key_in = 1'b0;
      wait_long(60);
      l0 = t_long;
      go_until(l0 + 3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; q = cyc;
      chk("midreset_outputs", {key_state, short_press, long_press, repeat_pulse}, 4'b0);
      wait_rise(20);
      chk("midreset_rise_lat", t_rise - q, 7);
      wait_long(40);
      chk("midreset_long_lat", t_long - t_rise, 20);
      chk("midreset_long_count", n_long - s_long, 2);
      key_in = 1'b1;
      go_until(cyc + 14);
      chk("midreset_final_level", key_state, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
